// File: rtl/motor_speed_ctrl.sv
// rtl/motor_speed_ctrl.sv - PI speed regulator with period-aligned PWM drive
// Five-stage update pipeline per encoder window; new duty latches only at PWM wrap.
module motor_speed_ctrl #(
    parameter int SAMPLE_CYCLES = 1250000,
    parameter int PWM_PERIOD    = 2500,
    parameter int KP            = 4,
    parameter int KI            = 1,
    parameter int SHIFT         = 4,
    parameter int INT_LIM       = 32767
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] setpoint,
    input  logic        [15:0] speed,
    input  logic        [7:0]  direction,
    output logic               pwm,
    output logic               dir_out,
    output logic        [15:0] duty,
    output logic               saturated,
    output logic               sample_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_ERR, S_INTEG, S_SUM, S_CLAMP
    } state_t;

    localparam logic signed [24:0] LIM25 = 25'(INT_LIM);
    localparam logic signed [23:0] LIM24 = 24'(INT_LIM);
    localparam logic signed [41:0] KP42  = 42'(KP);
    localparam logic signed [41:0] KI42  = 42'(KI);

    state_t              r_state;
    state_t              w_next;
    logic        [31:0]  r_scnt;
    logic        [15:0]  r_pcnt;
    logic signed [16:0]  r_meas;
    logic signed [17:0]  r_err;
    logic signed [23:0]  r_integ;
    logic signed [41:0]  r_u;
    logic        [15:0]  r_pending_duty;
    logic                r_pending_dir;
    logic                r_saturated;
    logic        [15:0]  r_duty;
    logic                r_dir;
    logic                r_pwm;

    logic                w_tick;
    logic signed [16:0]  w_speed_s;
    logic signed [24:0]  w_integ_sum;
    logic signed [23:0]  w_integ_next;
    logic signed [41:0]  w_err42;
    logic signed [41:0]  w_int42;
    logic signed [41:0]  w_pi;
    logic        [41:0]  w_mag;
    logic                w_sat;
    logic        [15:0]  w_duty_eff;
    logic                w_unused;

    assign w_unused  = ^direction[7:1];
    assign w_tick    = (r_scnt == 32'(SAMPLE_CYCLES - 1));
    assign w_speed_s = {1'b0, speed};

    assign w_integ_sum  = {r_integ[23], r_integ} + {{7{r_err[17]}}, r_err};
    assign w_integ_next = (w_integ_sum > LIM25)  ? LIM24 :
                          (w_integ_sum < -LIM25) ? -LIM24 : w_integ_sum[23:0];

    assign w_err42 = {{24{r_err[17]}}, r_err};
    assign w_int42 = {{18{r_integ[23]}}, r_integ};
    assign w_pi    = KP42 * w_err42 + KI42 * w_int42;

    assign w_mag = r_u[41] ? 42'(-r_u) : 42'(r_u);
    assign w_sat = (w_mag > 42'(PWM_PERIOD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_scnt <= '0;
        else if (w_tick) r_scnt <= '0;
        else             r_scnt <= r_scnt + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_tick) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_ERR;
            S_ERR:     w_next = S_INTEG;
            S_INTEG:   w_next = S_SUM;
            S_SUM:     w_next = S_CLAMP;
            S_CLAMP:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meas         <= '0;
            r_err          <= '0;
            r_integ        <= '0;
            r_u            <= '0;
            r_pending_duty <= '0;
            r_pending_dir  <= 1'b1;
            r_saturated    <= 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: r_meas  <= direction[0] ? w_speed_s : -w_speed_s;
                S_ERR:     r_err   <= {{2{setpoint[15]}}, setpoint} - {r_meas[16], r_meas};
                S_INTEG:   r_integ <= w_integ_next;
                S_SUM:     r_u     <= w_pi >>> SHIFT;
                S_CLAMP: begin
                    // Disabled drive parks at zero duty, forward direction
                    if (enable) begin
                        r_pending_duty <= w_sat ? 16'(PWM_PERIOD) : w_mag[15:0];
                        r_pending_dir  <= ~r_u[41];
                        r_saturated    <= w_sat;
                    end else begin
                        r_pending_duty <= '0;
                        r_pending_dir  <= 1'b1;
                        r_saturated    <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (!enable) r_integ <= '0;
        end
    end

    // Compare against the value being loaded at wrap so the first pulse of a period is correct
    assign w_duty_eff = (r_pcnt == 16'd0) ? r_pending_duty : r_duty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
            r_duty <= '0;
            r_dir  <= 1'b1;
            r_pwm  <= 1'b0;
        end else begin
            r_pcnt <= (r_pcnt == 16'(PWM_PERIOD - 1)) ? 16'd0 : r_pcnt + 16'd1;
            if (r_pcnt == 16'd0) begin
                r_duty <= r_pending_duty;
                r_dir  <= r_pending_dir;
            end
            r_pwm <= (r_pcnt < w_duty_eff);
        end
    end

    assign pwm         = r_pwm;
    assign dir_out     = r_dir;
    assign duty        = r_duty;
    assign saturated   = r_saturated;
    assign sample_done = (r_state == S_CLAMP);

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// tb/tb_motor_speed_ctrl.sv - scoreboard bench for motor_speed_ctrl
module tb_motor_speed_ctrl;

    localparam int SC = 2600;
    localparam int PP = 2500;
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] setpoint = '0;
    logic [15:0] speed = '0;
    logic [7:0]  direction = 8'd1;
    logic        pwm, dir_out, saturated, sample_done;
    logic [15:0] duty;

    motor_speed_ctrl #(.SAMPLE_CYCLES(SC), .PWM_PERIOD(PP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .setpoint(setpoint),
        .speed(speed), .direction(direction), .pwm(pwm), .dir_out(dir_out),
        .duty(duty), .saturated(saturated), .sample_done(sample_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   duty;
        logic dir;
        logic sat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   cyc = 0;

    int v_en [NV] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    int v_sp [NV] = '{100, 0, 100, 0, -50, 0, 0, 0, 32767, 32767, 32767, -8000, 0, 100};
    int v_spd[NV] = '{0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 3000, 0};
    int v_dr [NV] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int e_duty[NV] = '{31, 0, 31, 0, 16, 0, 6, 0, 2500, 2500, 2500, 453, 610, 31};
    int e_dir [NV] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int e_sat [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input int k);
        exp_t e;
        enable    = v_en[k][0];
        setpoint  = 16'(v_sp[k]);
        speed     = 16'(v_spd[k]);
        direction = {7'd0, v_dr[k][0]};
        e.duty = e_duty[k];
        e.dir  = e_dir[k][0];
        e.sat  = e_sat[k][0];
        q.push_back(e);
    endtask

    task automatic wait_done(input int k);
        bit ok = 0;
        for (int i = 0; i < 6000; i++) begin
            if (n_done > k) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sample_timeout: sample %0d never completed", k);
        end
    endtask

    task automatic wait_mod(input int m);
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (cyc % m == 0) break;
        end
    endtask

    task automatic count_window(input string name, input int exp);
        int cnt = 0;
        wait_mod(PP);
        repeat (PP) begin
            @(posedge clk); #1;
            cnt += int'(pwm);
        end
        check(name, cnt, exp);
    endtask

    // Monitor: pops one expectation per completed sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_done === 1'b1) begin
                n_done++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample_done: n=%0d with empty scoreboard", n_done);
                end else begin
                    e = q.pop_front();
                    @(posedge clk); #1;
                    check($sformatf("saturated[%0d]", n_done - 1), int'(saturated), int'(e.sat));
                    repeat (PP + 5) @(posedge clk);
                    #1;
                    check($sformatf("duty[%0d]", n_done - 1), int'(duty), e.duty);
                    check($sformatf("dir_out[%0d]", n_done - 1), int'(dir_out), int'(e.dir));
                end
            end
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm), 0);
        check("rst_dir_out", int'(dir_out), 1);
        check("rst_duty", int'(duty), 0);
        check("rst_saturated", int'(saturated), 0);
        check("rst_sample_done", int'(sample_done), 0);
        reset = 1'b0;

        apply(0);
        for (int k = 0; k <= 12; k++) begin
            wait_done(k);
            if (k + 1 <= 12) apply(k + 1);
            // Pending duty changes mid-window; width must stay that of the period start
            if (k == 0) count_window("pwm_width_31", 31);
            if (k == 9) count_window("pwm_width_full", PP);
        end

        wait_mod(SC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_duty", int'(duty), 0);
        check("midrst_saturated", int'(saturated), 0);
        check("midrst_sample_done", int'(sample_done), 0);
        check("midrst_dir_out", int'(dir_out), 1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        apply(13);
        wait_done(13);
        repeat (PP + 20) @(posedge clk);
        #1;
        check("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
